// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle plus the register-bus outputs of spi_regfile_peripheral.
// The master side drives the pins (controller or bench). The slave side is the peripheral.
interface spi_regfile_peripheral_if #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
);
  logic                         nCS;
  logic                         SCLK;
  logic                         COPI;
  logic                         CIPO;
  logic                         cipo_oe;
  logic [NUM_REGS*DATA_W-1:0]   regs_out;
  logic                         wr_strobe;
  logic [ADDR_W-1:0]            wr_addr;
  logic                         frame_err;

  modport master (
    output nCS, SCLK, COPI,
    input  CIPO, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err
  );

  modport slave (
    input  nCS, SCLK, COPI,
    output CIPO, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err
  );
endinterface

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral.
// Frames are R/W bit, address, then data, MSB first. Writes commit when nCS rises.
// Reads return reg[addr] on CIPO during the data phase.
//
// state  | meaning
// IDLE   | nCS_sync high, no frame in progress
// ADDR   | nCS low, R/W and address bits still arriving
// DATA   | address complete, data bits arriving (or read data shifting out)
// END    | nCS rise seen; frame verdict is applied on this cycle
module spi_regfile_peripheral #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic rst,
  spi_regfile_peripheral_if.slave bus
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA0 = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_END} state_t;

  state_t state, state_n;

  logic ncs_s1, ncs_s2, ncs_h;
  logic sclk_s1, sclk_s2, sclk_h;
  logic copi_s1, copi_s2;
  logic sclk_rise, sclk_fall, ncs_rise;

  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] rx_shift, rx_next;
  logic [DATA_W-1:0]  tx_shift, rd_data;
  logic [ADDR_W-1:0]  addr_now, frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               frame_rw, addr_ok;
  logic               end_ok, end_err;
  logic               commit, discard_err;

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic               wr_strobe_q, frame_err_q;
  logic [ADDR_W-1:0]  wr_addr_q;

  assign sclk_rise = sclk_s2 & ~sclk_h;
  assign sclk_fall = ~sclk_s2 & sclk_h;
  assign ncs_rise  = ncs_s2 & ~ncs_h;

  assign rx_next    = {rx_shift[FRAME_W-2:0], copi_s2};
  assign addr_now   = rx_next[ADDR_W-1:0];
  assign frame_rw   = rx_shift[FRAME_W-1];
  assign frame_addr = rx_shift[DATA_W +: ADDR_W];
  assign frame_data = rx_shift[DATA_W-1:0];
  assign addr_ok    = int'(frame_addr) < NUM_REGS;

  // Two-flop synchronisers plus history flops, reset to idle pin levels so release is edge-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_s1  <= 1'b1;
      ncs_s2  <= 1'b1;
      ncs_h   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_h  <= 1'b0;
      copi_s1 <= 1'b0;
      copi_s2 <= 1'b0;
    end else begin
      ncs_s1  <= bus.nCS;
      ncs_s2  <= ncs_s1;
      ncs_h   <= ncs_s2;
      sclk_s1 <= bus.SCLK;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      copi_s1 <= bus.COPI;
      copi_s2 <= copi_s1;
    end
  end

  // Bit counter (saturating one past a full frame) and receive shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rx_shift <= '0;
    end else if (ncs_s2) begin
      cnt <= '0;
    end else if (sclk_rise) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (cnt < CNT_FRAME) rx_shift <= rx_next;
    end
  end

  // Read mux; unimplemented addresses read as zero because no entry matches
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_now == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  // Transmit shifter: loaded as the address completes on a read, shifted after each data bit.
  // It stays zero outside a read data phase, so CIPO can come straight from its MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (ncs_s2) begin
      tx_shift <= '0;
    end else if (sclk_rise && (cnt == CNT_ADDR) && !rx_next[ADDR_W]) begin
      tx_shift <= rd_data;
    end else if (sclk_fall && (cnt > CNT_DATA0)) begin
      tx_shift <= tx_shift << 1;
    end
  end

  // Frame verdict, captured while the bit count is still valid (it clears on the same edge)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_ok  <= 1'b0;
      end_err <= 1'b0;
    end else if (ncs_rise && ((state == S_ADDR) || (state == S_DATA))) begin
      end_ok  <= (cnt == CNT_FRAME) && frame_rw && addr_ok;
      end_err <= (cnt != '0) && (cnt != CNT_FRAME);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next state and commit/error decode
  always_comb begin
    state_n     = state;
    commit      = 1'b0;
    discard_err = 1'b0;
    case (state)
      S_IDLE: if (!ncs_s2) state_n = S_ADDR;
      S_ADDR: begin
        if (ncs_rise)              state_n = S_END;
        else if (cnt >= CNT_DATA0) state_n = S_DATA;
      end
      S_DATA: if (ncs_rise) state_n = S_END;
      S_END: begin
        commit      = end_ok;
        discard_err = end_err;
        state_n     = ncs_s2 ? S_IDLE : S_ADDR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Register file and the commit/error strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= commit;
      frame_err_q <= discard_err;
      if (commit) begin
        wr_addr_q <= frame_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (frame_addr == ADDR_W'(i)) regs[i] <= frame_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

  assign bus.CIPO      = tx_shift[DATA_W-1];
  assign bus.cipo_oe   = ~ncs_s2;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.frame_err = frame_err_q;

endmodule
